// File: rtl/ika9958_regfile.sv
// ika9958_regfile: V9958 control registers R#0..R#(NREG-1) with port #1 and port #3 (via R#IDX_REG) write protocols.
// Define IKA9958_REG_READBACK_EN to enable registered port #3 readback on o_RDATA.
module ika9958_regfile #(
  parameter int NREG       = 64,
  parameter int IDX_REG    = 17,
  parameter bit ZMASK_FILL = 1'b1
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST_n,
  input  logic              i_CEN,
  input  logic              i_WR_STB,
  input  logic              i_RD_STB,
  input  logic [1:0]        i_PORT,
  input  logic [7:0]        i_DIN,
  output logic [NREG*8-1:0] o_REGFILE,
  output logic              o_REG_WE,
  output logic [5:0]        o_REG_WADDR,
  output logic              o_VADDR_STB,
  output logic [13:0]       o_VADDR,
  output logic              o_VADDR_WR,
  output logic [7:0]        o_RDATA
);

  localparam logic [5:0] IDX = 6'(IDX_REG);

  typedef enum logic {FIRST, SECOND} p1_state_t;

  p1_state_t  state;
  logic [7:0] latch;
  // Full 64-entry space; entries >= NREG are never written and stay at zero.
  logic [7:0] regs [64];

  logic       wr_en;
  logic       rd_en;
  logic       p3_wr;
  logic       p3_rd;
  logic [5:0] ptr;
  logic       aii;
  logic       ptr_ok;
  logic       ptr_bump;

  function automatic logic [7:0] wmask(input logic [5:0] idx);
    logic [7:0] m;
    m = 8'hFF;
    if (ZMASK_FILL) begin
      if (idx == 6'd9)  m = 8'hCE;
      if (idx == 6'd15) m = 8'hBF;
    end
    return m;
  endfunction

  function automatic logic in_range(input logic [5:0] idx);
    return ({1'b0, idx} < 7'(NREG));
  endfunction

  assign wr_en    = i_CEN & i_WR_STB;
  assign rd_en    = i_CEN & i_RD_STB;
  assign p3_wr    = wr_en && (i_PORT == 2'd3);
  assign ptr      = regs[IDX][5:0];
  assign aii      = regs[IDX][7];
  assign ptr_ok   = (ptr != IDX) && in_range(ptr);
  // The pointer advances on every port #3 access, even when the data is dropped.
  assign ptr_bump = (p3_wr || p3_rd) && !aii;

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int n = 0; n < 64; n++) regs[n] <= 8'h00;
      state       <= FIRST;
      latch       <= 8'h00;
      o_REG_WE    <= 1'b0;
      o_REG_WADDR <= 6'd0;
      o_VADDR_STB <= 1'b0;
      o_VADDR     <= 14'd0;
      o_VADDR_WR  <= 1'b0;
    end else begin
      o_REG_WE    <= 1'b0;
      o_VADDR_STB <= 1'b0;
      if (wr_en) begin
        case (i_PORT)
          2'd0: state <= FIRST;
          2'd1: begin
            if (state == FIRST) begin
              latch <= i_DIN;
              state <= SECOND;
            end else begin
              state <= FIRST;
              if (i_DIN[7:6] == 2'b10) begin
                if (in_range(i_DIN[5:0])) begin
                  regs[i_DIN[5:0]] <= latch & wmask(i_DIN[5:0]);
                  o_REG_WE         <= 1'b1;
                  o_REG_WADDR      <= i_DIN[5:0];
                end
              end else if (!i_DIN[7]) begin
                o_VADDR_STB <= 1'b1;
                o_VADDR     <= {i_DIN[5:0], latch};
                o_VADDR_WR  <= i_DIN[6];
              end
            end
          end
          2'd3: begin
            if (ptr_ok) begin
              regs[ptr]   <= i_DIN & wmask(ptr);
              o_REG_WE    <= 1'b1;
              o_REG_WADDR <= ptr;
            end
          end
          default: ;
        endcase
      end
      if (ptr_bump) regs[IDX] <= {regs[IDX][7:6], ptr + 6'd1} & wmask(IDX);
      // A read on port 0/1 aborts any pending two-byte sequence after the write is handled.
      if (rd_en && !i_PORT[1]) state <= FIRST;
    end
  end

`ifdef IKA9958_REG_READBACK_EN
  assign p3_rd = rd_en && (i_PORT == 2'd3);

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      o_RDATA <= 8'h00;
    end else if (p3_rd) begin
      o_RDATA <= in_range(ptr) ? regs[ptr] : 8'h00;
    end
  end
`else
  assign p3_rd   = 1'b0;
  assign o_RDATA = 8'h00;
`endif

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_img
      assign o_REGFILE[8*g +: 8] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_ika9958_regfile.sv
// tb_ika9958_regfile: scoreboard bench for ika9958_regfile; expected pulses are queued when stimulus is driven.
module tb_ika9958_regfile;

  localparam int NREG = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cen;
  logic              wr_stb;
  logic              rd_stb;
  logic [1:0]        port;
  logic [7:0]        din;
  logic [NREG*8-1:0] regfile;
  logic              reg_we;
  logic [5:0]        reg_waddr;
  logic              vaddr_stb;
  logic [13:0]       vaddr;
  logic              vaddr_wr;
  logic [7:0]        rdata;

  typedef struct {
    bit         isVaddr;
    logic [5:0] addr;
    logic [13:0] val;
    bit         wr;
  } expEvt_t;

  expEvt_t     scoreboard[$];
  logic [7:0]  expRegs [NREG];
  int          checkCount = 0;
  int          errCount = 0;

  ika9958_regfile #(.NREG(NREG), .IDX_REG(17), .ZMASK_FILL(1'b1)) dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_CEN(cen), .i_WR_STB(wr_stb), .i_RD_STB(rd_stb),
    .i_PORT(port), .i_DIN(din), .o_REGFILE(regfile), .o_REG_WE(reg_we), .o_REG_WADDR(reg_waddr),
    .o_VADDR_STB(vaddr_stb), .o_VADDR(vaddr), .o_VADDR_WR(vaddr_wr), .o_RDATA(rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] regAt(input logic [5:0] idx);
    return regfile[8*idx +: 8];
  endfunction

  task automatic checkImage(input string tag);
    logic [NREG*8-1:0] img;
    for (int n = 0; n < NREG; n++) img[8*n +: 8] = expRegs[n];
    checkOutput(tag, 512'(regfile), 512'(img));
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [1:0] p, input logic [7:0] d,
                               input bit en = 1'b1);
    @(posedge clk); #1;
    wr_stb = wr; rd_stb = rd; port = p; din = d; cen = en;
    @(posedge clk); #1;
    wr_stb = 1'b0; rd_stb = 1'b0; cen = 1'b1;
  endtask

  task automatic p1Write(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 2'd1, d);
  endtask

  task automatic expectReg(input logic [5:0] idx, input logic [7:0] val);
    expEvt_t e;
    e.isVaddr = 1'b0; e.addr = idx; e.val = 14'(val); e.wr = 1'b0;
    scoreboard.push_back(e);
    expRegs[idx] = val;
  endtask

  task automatic expectVaddr(input logic [13:0] a, input bit w);
    expEvt_t e;
    e.isVaddr = 1'b1; e.addr = 6'd0; e.val = a; e.wr = w;
    scoreboard.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 6 && scoreboard.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput(tag, 512'(scoreboard.size()), 512'(0));
    scoreboard.delete();
    checkImage({tag, "_img"});
  endtask

  // Every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (reg_we || vaddr_stb)) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_pulse", 512'({vaddr_stb, reg_we}), 512'(0));
      end else begin
        expEvt_t e;
        e = scoreboard.pop_front();
        checkOutput("pulse_kind", 512'({vaddr_stb, reg_we}), e.isVaddr ? 512'(2'b10) : 512'(2'b01));
        if (!e.isVaddr) begin
          checkOutput("waddr", 512'(reg_waddr), 512'(e.addr));
          checkOutput("wdata", 512'(regAt(e.addr)), 512'(e.val[7:0]));
        end else begin
          checkOutput("vaddr", 512'(vaddr), 512'(e.val));
          checkOutput("vaddr_wr", 512'(vaddr_wr), 512'(e.wr));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; cen = 1'b1; wr_stb = 1'b0; rd_stb = 1'b0; port = 2'd0; din = 8'h00;
    for (int n = 0; n < NREG; n++) expRegs[n] = 8'h00;
    #23;
    checkImage("reset_img");
    checkOutput("reset_we", 512'(reg_we), 512'(0));
    checkOutput("reset_vstb", 512'(vaddr_stb), 512'(0));
    checkOutput("reset_rdata", 512'(rdata), 512'(0));
    rst_n = 1'b1;

    expectReg(6'd7, 8'h1F); p1Write(8'h1F); p1Write(8'h87);
    waitDrain("r7");

    expectVaddr(14'h1234, 1'b1); p1Write(8'h34); p1Write(8'h52);
    waitDrain("vaddr");

    p1Write(8'hAA);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00);
    p1Write(8'h85);
    waitDrain("abort");
    expectReg(6'd5, 8'h85); p1Write(8'h85);
    waitDrain("r5");

    expectReg(6'd17, 8'h3E); p1Write(8'h3E); p1Write(8'h91);
    expectReg(6'd62, 8'h11); applyStimulus(1'b1, 1'b0, 2'd3, 8'h11);
    expectReg(6'd63, 8'h22); applyStimulus(1'b1, 1'b0, 2'd3, 8'h22);
    expectReg(6'd0, 8'h33);  applyStimulus(1'b1, 1'b0, 2'd3, 8'h33);
    expRegs[17] = 8'h01;
    waitDrain("autoinc");

    expectReg(6'd17, 8'hBE); p1Write(8'hBE); p1Write(8'h91);
    expectReg(6'd62, 8'h44); applyStimulus(1'b1, 1'b0, 2'd3, 8'h44);
    expectReg(6'd62, 8'h55); applyStimulus(1'b1, 1'b0, 2'd3, 8'h55);
    expectReg(6'd62, 8'h66); applyStimulus(1'b1, 1'b0, 2'd3, 8'h66);
    waitDrain("noinc");

    // Pointer aimed at the index register itself: data dropped, pointer still advances.
    expectReg(6'd17, 8'h11); p1Write(8'h11); p1Write(8'h91);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h77);
    expRegs[17] = 8'h12;
    waitDrain("self_ptr");
    expectReg(6'd18, 8'h5A); applyStimulus(1'b1, 1'b0, 2'd3, 8'h5A);
    expRegs[17] = 8'h13;
    waitDrain("after_self");

    expectReg(6'd9, 8'hCE);  p1Write(8'hFF); p1Write(8'h89);
    expectReg(6'd15, 8'hBF); p1Write(8'hFF); p1Write(8'h8F);
    waitDrain("zmask");

    p1Write(8'h12); p1Write(8'hC3);
    expectReg(6'd4, 8'h87); p1Write(8'h87); p1Write(8'h84);
    waitDrain("second_11");

    p1Write(8'h1F);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'hFF);
    expectReg(6'd2, 8'h1F); p1Write(8'h82);
    waitDrain("port2");

    applyStimulus(1'b1, 1'b0, 2'd1, 8'h99, 1'b0);
    expectReg(6'd3, 8'h21); p1Write(8'h21); p1Write(8'h83);
    waitDrain("cen_low");

    p1Write(8'h40);
    expectReg(6'd6, 8'h40); applyStimulus(1'b1, 1'b1, 2'd1, 8'h86);
    expectReg(6'd7, 8'h23); p1Write(8'h23); p1Write(8'h87);
    waitDrain("rd_wr_same");

    expectReg(6'd17, 8'h07); p1Write(8'h07); p1Write(8'h91);
    waitDrain("ptr7");
    applyStimulus(1'b0, 1'b1, 2'd3, 8'h00);
    @(negedge clk);
`ifdef IKA9958_REG_READBACK_EN
    checkOutput("rdata", 512'(rdata), 512'(expRegs[7]));
    expRegs[17] = 8'h08;
`else
    checkOutput("rdata", 512'(rdata), 512'(0));
`endif
    checkImage("readback_img");

    p1Write(8'h55);
    #3 rst_n = 1'b0;
    #2;
    for (int n = 0; n < NREG; n++) expRegs[n] = 8'h00;
    checkImage("midseq_rst_img");
    @(posedge clk); #3 rst_n = 1'b1;
    expectReg(6'd2, 8'h87); p1Write(8'h87); p1Write(8'h82);
    waitDrain("post_rst");

    $display("[TB] done");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
